// File: rtl/reshape_stream_router.sv
`timescale 1ns/1ps
// Reshape stream router: steers one input stream to a one-hot selected engine and
// returns that engine's output through a 2-entry registered skid buffer.
module reshape_stream_router #(
   parameter int DATA_WIDTH = 128,
   parameter int NUM_ENG    = 4,
   parameter int CNT_WIDTH  = 24
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          cfg_valid,
   input  logic [NUM_ENG-1:0]            cfg_mode,
   input  logic [CNT_WIDTH-1:0]          cfg_in_beats,
   input  logic [CNT_WIDTH-1:0]          cfg_out_beats,
   output logic                          cfg_ready,
   input  logic [DATA_WIDTH-1:0]         s_data,
   input  logic                          s_valid,
   output logic                          s_ready,
   output logic [NUM_ENG*DATA_WIDTH-1:0] eng_s_data,
   output logic [NUM_ENG-1:0]            eng_s_valid,
   input  logic [NUM_ENG-1:0]            eng_s_ready,
   input  logic [NUM_ENG*DATA_WIDTH-1:0] eng_m_data,
   input  logic [NUM_ENG-1:0]            eng_m_valid,
   output logic [NUM_ENG-1:0]            eng_m_ready,
   output logic [DATA_WIDTH-1:0]         m_data,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic                          m_last,
   output logic                          busy,
   output logic                          done,
   output logic                          cfg_err
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
   localparam logic [NUM_ENG-1:0]   ENG_ZERO = {NUM_ENG{1'b0}};

   state_t                 state_r;
   logic [NUM_ENG-1:0]     sel_r;
   logic [CNT_WIDTH-1:0]   in_beats_r;
   logic [CNT_WIDTH-1:0]   out_beats_r;
   logic [CNT_WIDTH-1:0]   in_cnt_r;
   logic [CNT_WIDTH-1:0]   out_cnt_r;
   logic                   cfg_err_r;

   logic [DATA_WIDTH-1:0]  skid_data_r [2];
   logic [1:0]             skid_last_r;
   logic                   skid_wr_r;
   logic                   skid_rd_r;
   logic [1:0]             skid_cnt_r;

   logic                   in_open_s;
   logic                   out_open_s;
   logic                   skid_space_s;
   logic                   s_hs_s;
   logic                   push_s;
   logic                   pop_s;
   logic                   last_beat_s;
   logic [DATA_WIDTH-1:0]  eng_sel_data_s;

   function automatic logic is_onehot(input logic [NUM_ENG-1:0] mode);
      logic [NUM_ENG-1:0] mode_dec;
      mode_dec = mode - {{(NUM_ENG-1){1'b0}}, 1'b1};
      return (mode != ENG_ZERO) && ((mode & mode_dec) == ENG_ZERO);
   endfunction

   assign in_open_s  = ((state_r == ST_RUN) || (state_r == ST_FLUSH)) && (in_cnt_r < in_beats_r);
   assign out_open_s = (state_r == ST_RUN) && (out_cnt_r < out_beats_r);

   // A full skid can still take a beat in the same cycle its head is popped.
   assign skid_space_s = (skid_cnt_r != 2'd2) || m_ready;

   assign eng_s_data  = {NUM_ENG{s_data}};
   assign eng_s_valid = sel_r & {NUM_ENG{s_valid & in_open_s}};
   assign s_ready     = in_open_s && ((eng_s_ready & sel_r) != ENG_ZERO);
   assign s_hs_s      = s_valid && s_ready;

   assign eng_m_ready = sel_r & {NUM_ENG{out_open_s & skid_space_s}};
   assign push_s      = ((eng_m_valid & eng_m_ready) != ENG_ZERO);
   assign pop_s       = m_valid && m_ready;
   assign last_beat_s = ((out_cnt_r + CNT_ONE) == out_beats_r);

   // One-hot mux of the selected engine's output slice.
   always_comb begin
      eng_sel_data_s = {DATA_WIDTH{1'b0}};
      for (int k = 0; k < NUM_ENG; k++) begin
         if (sel_r[k]) begin
            eng_sel_data_s = eng_sel_data_s | eng_m_data[k*DATA_WIDTH +: DATA_WIDTH];
         end else begin
            eng_sel_data_s = eng_sel_data_s;
         end
      end
   end

   assign m_valid   = (skid_cnt_r != 2'd0);
   assign m_data    = skid_data_r[skid_rd_r];
   assign m_last    = skid_last_r[skid_rd_r] & m_valid;
   assign cfg_ready = (state_r == ST_IDLE);
   assign busy      = (state_r != ST_IDLE);
   assign done      = (state_r == ST_DONE);
   assign cfg_err   = cfg_err_r;

   // Layer sequencing FSM with configuration latch and saturating beat counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         sel_r       <= ENG_ZERO;
         in_beats_r  <= CNT_ZERO;
         out_beats_r <= CNT_ZERO;
         in_cnt_r    <= CNT_ZERO;
         out_cnt_r   <= CNT_ZERO;
         cfg_err_r   <= 1'b0;
      end else begin
         cfg_err_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (cfg_valid) begin
                  if (is_onehot(cfg_mode) && (cfg_out_beats != CNT_ZERO)) begin
                     sel_r       <= cfg_mode;
                     in_beats_r  <= cfg_in_beats;
                     out_beats_r <= cfg_out_beats;
                     in_cnt_r    <= CNT_ZERO;
                     out_cnt_r   <= CNT_ZERO;
                     state_r     <= ST_RUN;
                  end else begin
                     cfg_err_r <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (s_hs_s) begin
                  in_cnt_r <= in_cnt_r + CNT_ONE;
               end
               if (push_s) begin
                  out_cnt_r <= out_cnt_r + CNT_ONE;
               end
               if (out_cnt_r == out_beats_r) begin
                  state_r <= ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               if (s_hs_s) begin
                  in_cnt_r <= in_cnt_r + CNT_ONE;
               end
               if ((skid_cnt_r == 2'd0) && (in_cnt_r == in_beats_r)) begin
                  state_r <= ST_DONE;
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Two-entry skid FIFO between the engine mux and the downstream port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_data_r[0] <= {DATA_WIDTH{1'b0}};
         skid_data_r[1] <= {DATA_WIDTH{1'b0}};
         skid_last_r    <= 2'b00;
         skid_wr_r      <= 1'b0;
         skid_rd_r      <= 1'b0;
         skid_cnt_r     <= 2'd0;
      end else begin
         if (push_s) begin
            skid_data_r[skid_wr_r] <= eng_sel_data_s;
            skid_last_r[skid_wr_r] <= last_beat_s;
            skid_wr_r              <= ~skid_wr_r;
         end
         if (pop_s) begin
            skid_rd_r <= ~skid_rd_r;
         end
         case ({push_s, pop_s})
            2'b10:   skid_cnt_r <= skid_cnt_r + 2'd1;
            2'b01:   skid_cnt_r <= skid_cnt_r - 2'd1;
            default: skid_cnt_r <= skid_cnt_r;
         endcase
      end
   end

endmodule
